// File: rtl/mult_div_sequencer_if.sv
// Execute-stage port bundle for the HI/LO multiply/divide sequencer.
// The sequencer uses the slave side; the pipeline (or bench) uses the master side.
interface mult_div_sequencer_if #(
  parameter int NB_DATA   = 32,
  parameter int NB_FCODE  = 6,
  parameter int NB_OPCODE = 6
);
  logic                 i_valid;
  logic [NB_OPCODE-1:0] i_instruction_opcode;
  logic [NB_FCODE-1:0]  i_funct_code;
  logic [NB_DATA-1:0]   i_rs_data;
  logic [NB_DATA-1:0]   i_rt_data;
  logic [NB_DATA-1:0]   o_hilo_data;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_stall;

  modport master (
    output i_valid, i_instruction_opcode, i_funct_code, i_rs_data, i_rt_data,
    input  o_hilo_data, o_busy, o_done, o_stall
  );

  modport slave (
    input  i_valid, i_instruction_opcode, i_funct_code, i_rs_data, i_rt_data,
    output o_hilo_data, o_busy, o_done, o_stall
  );
endinterface

// File: rtl/mult_div_sequencer.sv
// MIPS HI/LO unit: 32-step shift-add multiply / restoring divide, plus MFHI/MFLO/MTHI/MTLO.
// Signed ops run on magnitudes; sign correction and the HI/LO write happen in FIX.
module mult_div_sequencer #(
  parameter int NB_DATA   = 32,
  parameter int NB_FCODE  = 6,
  parameter int NB_OPCODE = 6
) (
  input  logic i_clk,
  input  logic i_reset,
  mult_div_sequencer_if.slave bus
);
  localparam int NB_CNT = $clog2(NB_DATA);
  localparam logic [NB_OPCODE-1:0] RTYPE = '0;
  localparam logic [NB_FCODE-1:0] F_MFHI  = NB_FCODE'(6'h10);
  localparam logic [NB_FCODE-1:0] F_MTHI  = NB_FCODE'(6'h11);
  localparam logic [NB_FCODE-1:0] F_MFLO  = NB_FCODE'(6'h12);
  localparam logic [NB_FCODE-1:0] F_MTLO  = NB_FCODE'(6'h13);
  localparam logic [NB_FCODE-1:0] F_MULT  = NB_FCODE'(6'h18);
  localparam logic [NB_FCODE-1:0] F_MULTU = NB_FCODE'(6'h19);
  localparam logic [NB_FCODE-1:0] F_DIV   = NB_FCODE'(6'h1A);
  localparam logic [NB_FCODE-1:0] F_DIVU  = NB_FCODE'(6'h1B);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t                 state_q, state_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;
  logic [2*NB_DATA-1:0]   acc_q, acc_d;
  logic [NB_DATA-1:0]     opnd_q, opnd_d;
  logic [NB_DATA-1:0]     rs_raw_q, rs_raw_d;
  logic [NB_DATA-1:0]     hi_q, hi_d;
  logic [NB_DATA-1:0]     lo_q, lo_d;
  logic                   is_div_q, is_div_d;
  logic                   neg_q, neg_d;
  logic                   rem_neg_q, rem_neg_d;
  logic                   dbz_q, dbz_d;

  // Decode
  logic [NB_FCODE-1:0] fc;
  logic rtype_v, is_mf, is_mt, is_md, req;
  assign fc      = bus.i_funct_code;
  assign rtype_v = bus.i_valid && (bus.i_instruction_opcode == RTYPE);
  assign is_mf   = (fc == F_MFHI) || (fc == F_MFLO);
  assign is_mt   = (fc == F_MTHI) || (fc == F_MTLO);
  assign is_md   = (fc == F_MULT) || (fc == F_MULTU) || (fc == F_DIV) || (fc == F_DIVU);
  assign req     = rtype_v && (is_mf || is_mt || is_md);

  assign bus.o_stall     = req && (state_q != IDLE);
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_done      = (state_q == FIX);
  assign bus.o_hilo_data = (rtype_v && fc == F_MFHI) ? hi_q :
                           (rtype_v && fc == F_MFLO) ? lo_q : '0;

  // Operand magnitudes; funct bit 0 clear means signed, bit 1 set means divide
  logic               op_signed, rs_neg, rt_neg;
  logic [NB_DATA-1:0] rs_mag, rt_mag;
  assign op_signed = ~fc[0];
  assign rs_neg    = op_signed && bus.i_rs_data[NB_DATA-1];
  assign rt_neg    = op_signed && bus.i_rt_data[NB_DATA-1];
  assign rs_mag    = rs_neg ? -bus.i_rs_data : bus.i_rs_data;
  assign rt_mag    = rt_neg ? -bus.i_rt_data : bus.i_rt_data;

  // One iteration step. Multiply: acc = {partial, multiplier}, shifted right.
  // Divide: acc = {remainder, dividend/quotient}, shifted left.
  logic [NB_DATA:0]     mul_sum, div_shift, div_diff;
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0]   quo_fix, rem_fix;
  assign mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} +
                     (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = acc_q[2*NB_DATA-1:NB_DATA-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quo_fix   = neg_q ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
  assign rem_fix   = rem_neg_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    rs_raw_d  = rs_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (rtype_v && is_md) begin
          state_d   = ITER;
          cnt_d     = '0;
          is_div_d  = fc[1];
          neg_d     = rs_neg ^ rt_neg;
          rem_neg_d = rs_neg;
          dbz_d     = (bus.i_rt_data == '0);
          rs_raw_d  = bus.i_rs_data;
          opnd_d    = fc[1] ? rt_mag : rs_mag;
          acc_d     = {{NB_DATA{1'b0}}, (fc[1] ? rs_mag : rt_mag)};
        end else if (rtype_v && fc == F_MTHI) begin
          hi_d = bus.i_rs_data;
        end else if (rtype_v && fc == F_MTLO) begin
          lo_d = bus.i_rs_data;
        end
      end
      ITER: begin
        cnt_d = cnt_q + NB_CNT'(1);
        if (is_div_q)
          acc_d = {(div_diff[NB_DATA] ? div_shift[NB_DATA-1:0] : div_diff[NB_DATA-1:0]),
                   acc_q[NB_DATA-2:0], ~div_diff[NB_DATA]};
        else
          acc_d = {mul_sum, acc_q[NB_DATA-1:1]};
        if (cnt_q == '1) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (is_div_q && dbz_q) begin
          // Divide by zero: all-ones quotient, raw dividend as remainder, no sign fix
          lo_d = '1;
          hi_d = rs_raw_q;
        end else if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
          lo_d = prod_fix[NB_DATA-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      rs_raw_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      rs_raw_q  <= rs_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
    end
  end
endmodule
